// File: rtl/y_signature_compactor.sv
// -----------------------------------------------------------------------------
// y_signature_compactor
//
// Compacts the upstream `y` bus into a MISR signature over a programmed number
// of qualified samples, then offers the final signature through a valid/ready
// handshake. Two instances (one per netlist) let an equivalence harness compare
// short signatures instead of full output traces.
//
// Each qualified sample is zero-padded to a multiple of SIG_W bits. It is split
// into SIG_W-bit chunks, and all chunks are XORed into one fold word. The fold
// word is then mixed into the signature:
//     sig <= step(sig) ^ fold,  step(s) = (s << 1) ^ (s[MSB] ? POLY : 0)
//
// Ports:
//   clk         rising-edge clock shared with the upstream block
//   rst         synchronous active-high reset
//   y           upstream output bus sample (DATA_W bits)
//   y_valid     qualifies `y` this cycle
//   start       one-cycle capture request, honoured only in IDLE
//   num_cycles  qualified samples to compact, latched on start
//   busy        high in WARM, RUN and HOLD
//   sig         current signature register
//   sig_valid   final signature available (HOLD)
//   sig_ready   consumer accepts the signature
//   done        one-cycle pulse following the handshake transfer
//   sample_cnt  qualified samples folded so far in this run
// -----------------------------------------------------------------------------
module y_signature_compactor #(
    parameter int               DATA_W = 242,
    parameter int               SIG_W  = 32,
    parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED   = 32'hFFFFFFFF,
    parameter int               WARMUP = 0,
    parameter int               CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] y,
    input  logic              y_valid,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_cycles,
    output logic              busy,
    output logic [SIG_W-1:0]  sig,
    output logic              sig_valid,
    input  logic              sig_ready,
    output logic              done,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam int NCHUNK = (DATA_W + SIG_W - 1) / SIG_W;
    localparam int PAD_W  = NCHUNK * SIG_W;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] WARMUP_C = CNT_W'(WARMUP);
    localparam logic [SIG_W-1:0] SIG_ZERO = {SIG_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // XOR of all SIG_W-bit chunks of the zero-padded sample
    function automatic logic [SIG_W-1:0] fold_f(input logic [DATA_W-1:0] d);
        logic [PAD_W-1:0] pad;
        logic [SIG_W-1:0] acc;
        pad             = {PAD_W{1'b0}};
        pad[DATA_W-1:0] = d;
        acc             = SIG_ZERO;
        for (int k = 0; k < NCHUNK; k++) begin
            acc = acc ^ pad[k*SIG_W +: SIG_W];
        end
        return acc;
    endfunction

    // One Galois-style LFSR shift of the signature
    function automatic logic [SIG_W-1:0] misr_step_f(input logic [SIG_W-1:0] s);
        return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : SIG_ZERO);
    endfunction

    state_t           state_r, state_nx_s;
    logic [SIG_W-1:0] sig_r, sig_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic [CNT_W-1:0] warm_cnt_r, warm_nx_s;
    logic [CNT_W-1:0] num_r, num_nx_s;
    logic             done_r, done_nx_s;
    logic             busy_r;
    logic             sig_valid_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] warm_inc_s;

    assign cnt_inc_s  = cnt_r + CNT_ONE;
    assign warm_inc_s = warm_cnt_r + CNT_ONE;

    // Next-state and datapath update for the capture FSM
    always_comb begin
        state_nx_s = state_r;
        sig_nx_s   = sig_r;
        cnt_nx_s   = cnt_r;
        warm_nx_s  = warm_cnt_r;
        num_nx_s   = num_r;
        done_nx_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    sig_nx_s  = SEED;
                    cnt_nx_s  = CNT_ZERO;
                    warm_nx_s = CNT_ZERO;
                    num_nx_s  = num_cycles;
                    if (num_cycles == CNT_ZERO) begin
                        state_nx_s = ST_HOLD;
                    end else if (WARMUP > 0) begin
                        state_nx_s = ST_WARM;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WARM: begin
                if (y_valid) begin
                    warm_nx_s = warm_inc_s;
                    if (warm_inc_s == WARMUP_C) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        state_nx_s = ST_WARM;
                    end
                end else begin
                    state_nx_s = ST_WARM;
                end
            end
            ST_RUN: begin
                if (y_valid) begin
                    sig_nx_s = misr_step_f(sig_r) ^ fold_f(y);
                    cnt_nx_s = cnt_inc_s;
                    // num_r is non-zero here, so the count can never wrap
                    if (cnt_inc_s == num_r) begin
                        state_nx_s = ST_HOLD;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                // start is deliberately not looked at here
                if (sig_ready) begin
                    done_nx_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            sig_r       <= SEED;
            cnt_r       <= CNT_ZERO;
            warm_cnt_r  <= CNT_ZERO;
            num_r       <= CNT_ZERO;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            sig_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            sig_r       <= sig_nx_s;
            cnt_r       <= cnt_nx_s;
            warm_cnt_r  <= warm_nx_s;
            num_r       <= num_nx_s;
            done_r      <= done_nx_s;
            busy_r      <= (state_nx_s != ST_IDLE);
            sig_valid_r <= (state_nx_s == ST_HOLD);
        end
    end

    assign busy       = busy_r;
    assign sig        = sig_r;
    assign sig_valid  = sig_valid_r;
    assign done       = done_r;
    assign sample_cnt = cnt_r;

endmodule
